ring_input_buffer: RTL and testbench

- Per-port input unit of the ring router: a FIFO of whole packets that sits directly upstream of route_info_update.
- Presents the head packet to route_info_update and pulses its update enable once per head.
- Captures the returned direction and requests the switch allocator until granted.
- Pops the head on grant, so the crossbar consumes the head and its direction.

---
 rtl/ring_input_buffer_pkg.sv | 21 ++
 rtl/ring_input_buffer_if.sv | 33 +++
 rtl/ring_input_buffer_fifo_mem.sv | 49 ++++
 rtl/ring_input_buffer.sv | 99 +++++++++
 tb/tb_ring_input_buffer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_input_buffer_pkg.sv
// Shared ring-router types: direction codes, packet field positions and input-unit FSM states.
package ring_pkg;

  typedef enum logic [1:0] {
    DIR_LOCAL = 2'b00,
    DIR_EAST  = 2'b01,
    DIR_WEST  = 2'b10
  } dir_t;

  localparam int unsigned DEST_LSB            = 0;
  localparam int unsigned DEST_MSB            = 15;
  localparam int unsigned TS_LSB_BIT          = 32;
  localparam int unsigned PACKET_SIZE_DEFAULT = 49;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUTE = 2'b01,
    REQ   = 2'b10
  } fsm_t;

endpackage

// File: rtl/ring_input_buffer_if.sv
// Link, route-compute and switch-allocator signals of one ring input unit.
interface ring_input_buffer_if
  import ring_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = PACKET_SIZE_DEFAULT,
  parameter int unsigned DEPTH       = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                   in_valid;
  logic [PACKET_SIZE-1:0] in_data;
  logic                   in_ready;
  logic [PACKET_SIZE-1:0] head_data;
  logic                   route_update_en;
  logic [1:0]             out_dir;
  logic                   sa_req;
  logic [1:0]             sa_dir;
  logic                   sa_gnt;
  logic [CW-1:0]          occupancy;

  // Router side: drives the link, route result and grant.
  modport master (
    output in_valid, in_data, out_dir, sa_gnt,
    input  in_ready, head_data, route_update_en, sa_req, sa_dir, occupancy
  );

  // Input buffer side.
  modport slave (
    input  in_valid, in_data, out_dir, sa_gnt,
    output in_ready, head_data, route_update_en, sa_req, sa_dir, occupancy
  );

endinterface

// File: rtl/ring_input_buffer_fifo_mem.sv
// Packet storage for the input unit: circular buffer with pointers, count and full/empty flags.
module ring_fifo_mem #(
  parameter int unsigned WIDTH = 49,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  // Gate to zero when empty so nothing stale is ever presented.
  assign head    = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ring_input_buffer.sv
// Ring router input unit: packet FIFO, one route-compute pulse per head, allocator request until grant.
module ring_input_buffer
  import ring_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = PACKET_SIZE_DEFAULT,
  parameter int unsigned DEPTH       = 4
) (
  input logic               clk,
  input logic               rst_n,
  ring_input_buffer_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fsm_t          state_q;
  logic          route_en_q, sa_req_q, first_q;
  logic [1:0]    dir_q;
  logic          full, empty, push, pop;
  logic [CW-1:0] count, count_next;

  assign push = bus.in_valid && !full;
  assign pop  = (state_q == REQ) && bus.sa_gnt;

  ring_fifo_mem #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .head      (bus.head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      route_en_q <= 1'b0;
      sa_req_q   <= 1'b0;
      first_q    <= 1'b0;
      dir_q      <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Looking at the incoming push lets a fresh packet reach ROUTE the very next cycle.
          if (!empty || push) begin
            state_q    <= ROUTE;
            route_en_q <= 1'b1;
          end
        end
        ROUTE: begin
          state_q    <= REQ;
          route_en_q <= 1'b0;
          sa_req_q   <= 1'b1;
          first_q    <= 1'b1;
        end
        REQ: begin
          first_q <= 1'b0;
          if (first_q) dir_q <= bus.out_dir;
          if (bus.sa_gnt) begin
            sa_req_q <= 1'b0;
            if (count_next != '0) begin
              state_q    <= ROUTE;
              route_en_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          route_en_q <= 1'b0;
          sa_req_q   <= 1'b0;
        end
      endcase
    end
  end

  // The route result lands at the start of the first REQ cycle, so forward it until held in dir_q.
  always_comb begin
    bus.sa_dir = 2'b00;
    if (sa_req_q) bus.sa_dir = first_q ? bus.out_dir : dir_q;
  end

  assign bus.in_ready        = !full;
  assign bus.route_update_en = route_en_q;
  assign bus.sa_req          = sa_req_q;
  assign bus.occupancy       = count;

endmodule

// File: tb/tb_ring_input_buffer.sv
// Self-checking bench for ring_input_buffer against a queue-based packet model.
module tb_ring_input_buffer;
  import ring_pkg::*;

  localparam int unsigned PS = PACKET_SIZE_DEFAULT;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   pulse_cnt = 0;
  logic [PS-1:0] exp_q [$];

  always #5 clk = ~clk;

  ring_input_buffer_if #(.PACKET_SIZE(PS), .DEPTH(D)) bus ();

  ring_input_buffer #(.PACKET_SIZE(PS), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Stand-in routing decision of route_info_update: derived from the destination ID.
  function automatic logic [1:0] dir_of(input logic [PS-1:0] p);
    logic [15:0] dest;
    dest = p[DEST_MSB:DEST_LSB];
    case (dest % 16'd3)
      16'd0:   return DIR_LOCAL;
      16'd1:   return DIR_WEST;
      default: return DIR_EAST;
    endcase
  endfunction

  function automatic logic [PS-1:0] rand_pkt();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PS-1:0];
  endfunction

  // One clock cycle, entered and left at a falling edge. Keeps the packet queue model and the
  // route-compute model up to date; reports what left the buffer and what the model expected.
  task automatic cycle(input logic v, input logic [PS-1:0] d, input logic g,
                       output logic pushed, output logic popped, output logic [PS-1:0] pdata,
                       output logic [1:0] pdir, output logic [PS-1:0] edata);
    logic pulse;
    logic [PS-1:0] hd;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.sa_gnt   = g;
    #1;
    pulse  = bus.route_update_en;
    hd     = bus.head_data;
    popped = bus.sa_req && g;
    pdata  = bus.head_data;
    pdir   = bus.sa_dir;
    edata  = ~bus.head_data;
    if (popped && exp_q.size() > 0) edata = exp_q.pop_front();
    pushed = v && bus.in_ready;
    if (pushed) exp_q.push_back(d);
    if (pulse) pulse_cnt++;
    @(posedge clk);
    #1;
    bus.out_dir = pulse ? dir_of(hd) : 2'($urandom());
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic pu, po;
    logic [PS-1:0] pd, ed;
    logic [1:0] pr;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.sa_gnt = 1'b0;
    bus.out_dir = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
    checks++; if (bus.sa_req !== 1'b0) begin failures++; $display("FAIL reset_sa_req got=%0b want=0", bus.sa_req); end
    checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", bus.occupancy); end
    checks++; if (bus.sa_dir !== 2'b00) begin failures++; $display("FAIL reset_sa_dir got=%b want=00", bus.sa_dir); end
    checks++; if (bus.head_data !== '0) begin failures++; $display("FAIL reset_head got=%h want=0", bus.head_data); end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1, pu, po, pd, pr, ed);
      checks++; if (bus.route_update_en !== 1'b0) begin failures++; $display("FAIL idle_no_pulse cycle=%0d got=%0b want=0", i, bus.route_update_en); end
    end
  endtask

  task automatic test_single();
    logic pu, po;
    logic [PS-1:0] d, pd, ed;
    logic [1:0] pr;
    d = rand_pkt();
    d[15:0] = 16'h0005;
    cycle(1'b1, d, 1'b1, pu, po, pd, pr, ed);
    checks++; if (bus.route_update_en !== 1'b1) begin failures++; $display("FAIL single_pulse got=%0b want=1", bus.route_update_en); end
    checks++; if (bus.head_data !== d) begin failures++; $display("FAIL single_head got=%h want=%h", bus.head_data, d); end
    checks++; if (bus.occupancy !== CW'(1)) begin failures++; $display("FAIL single_occ1 got=%0d want=1", bus.occupancy); end
    cycle(1'b0, '0, 1'b1, pu, po, pd, pr, ed);
    checks++; if (po !== 1'b0) begin failures++; $display("FAIL single_no_pop_in_route got=%0b want=0", po); end
    checks++; if (bus.sa_req !== 1'b1) begin failures++; $display("FAIL single_req got=%0b want=1", bus.sa_req); end
    checks++; if (bus.sa_dir !== 2'b01) begin failures++; $display("FAIL single_dir got=%b want=01", bus.sa_dir); end
    checks++; if (bus.route_update_en !== 1'b0) begin failures++; $display("FAIL single_pulse_once got=%0b want=0", bus.route_update_en); end
    cycle(1'b0, '0, 1'b1, pu, po, pd, pr, ed);
    checks++; if (po !== 1'b1 || pd !== d) begin failures++; $display("FAIL single_pop got=%0b/%h want=1/%h", po, pd, d); end
    checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL single_occ0 got=%0d want=0", bus.occupancy); end
    checks++; if (bus.sa_req !== 1'b0) begin failures++; $display("FAIL single_idle_req got=%0b want=0", bus.sa_req); end
    cycle(1'b0, '0, 1'b1, pu, po, pd, pr, ed);
    checks++; if (bus.route_update_en !== 1'b0) begin failures++; $display("FAIL single_idle_pulse got=%0b want=0", bus.route_update_en); end
  endtask

  task automatic test_backpressure();
    logic pu, po;
    logic [PS-1:0] pd, ed;
    logic [1:0] pr, first_dir;
    int last_pop, pops;
    pulse_cnt = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_pkt(), 1'b0, pu, po, pd, pr, ed);
    checks++; if (bus.occupancy !== CW'(4)) begin failures++; $display("FAIL bp_full_occ got=%0d want=4", bus.occupancy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b want=0", bus.in_ready); end
    cycle(1'b1, rand_pkt(), 1'b0, pu, po, pd, pr, ed);
    checks++; if (bus.occupancy !== CW'(4)) begin failures++; $display("FAIL bp_refused_push got=%0d want=4", bus.occupancy); end
    checks++; if (bus.sa_req !== 1'b1) begin failures++; $display("FAIL bp_req got=%0b want=1", bus.sa_req); end
    first_dir = bus.sa_dir;
    checks++; if (first_dir !== dir_of(exp_q[0])) begin failures++; $display("FAIL bp_dir got=%b want=%b", first_dir, dir_of(exp_q[0])); end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0, pu, po, pd, pr, ed);
      checks++; if (bus.sa_dir !== first_dir) begin failures++; $display("FAIL bp_dir_stable cycle=%0d got=%b want=%b", i, bus.sa_dir, first_dir); end
    end
    checks++; if (pulse_cnt != 1) begin failures++; $display("FAIL bp_pulse_count got=%0d want=1", pulse_cnt); end
    last_pop = -1;
    pops = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      cycle(1'b0, '0, 1'b1, pu, po, pd, pr, ed);
      if (po) begin
        checks++; if (pd !== ed) begin failures++; $display("FAIL bp_order got=%h want=%h", pd, ed); end
        checks++; if (pr !== dir_of(ed)) begin failures++; $display("FAIL bp_pop_dir got=%b want=%b", pr, dir_of(ed)); end
        if (last_pop >= 0) begin
          checks++; if (c - last_pop != 2) begin failures++; $display("FAIL bp_spacing got=%0d want=2", c - last_pop); end
        end
        last_pop = c;
        pops++;
      end
      checks++; if (bus.occupancy !== CW'(exp_q.size())) begin failures++; $display("FAIL bp_drain_occ got=%0d want=%0d", bus.occupancy, exp_q.size()); end
    end
    checks++; if (pops != 4) begin failures++; $display("FAIL bp_pop_count got=%0d want=4", pops); end
  endtask

  task automatic test_simul();
    logic pu, po;
    logic [PS-1:0] d1, d2, pd, ed;
    logic [1:0] pr;
    d1 = rand_pkt();
    d2 = rand_pkt();
    cycle(1'b1, d1, 1'b0, pu, po, pd, pr, ed);
    cycle(1'b0, '0, 1'b0, pu, po, pd, pr, ed);
    checks++; if (bus.sa_req !== 1'b1 || bus.occupancy !== CW'(1)) begin failures++; $display("FAIL simul_setup got=%0b/%0d want=1/1", bus.sa_req, bus.occupancy); end
    cycle(1'b1, d2, 1'b1, pu, po, pd, pr, ed);
    checks++; if (po !== 1'b1 || pd !== d1) begin failures++; $display("FAIL simul_pop got=%0b/%h want=1/%h", po, pd, d1); end
    checks++; if (bus.occupancy !== CW'(1)) begin failures++; $display("FAIL simul_occ got=%0d want=1", bus.occupancy); end
    checks++; if (bus.route_update_en !== 1'b1) begin failures++; $display("FAIL simul_route got=%0b want=1", bus.route_update_en); end
    checks++; if (bus.head_data !== d2) begin failures++; $display("FAIL simul_head got=%h want=%h", bus.head_data, d2); end
    cycle(1'b0, '0, 1'b0, pu, po, pd, pr, ed);
    cycle(1'b0, '0, 1'b1, pu, po, pd, pr, ed);
    checks++; if (po !== 1'b1 || pd !== d2) begin failures++; $display("FAIL simul_pop2 got=%0b/%h want=1/%h", po, pd, d2); end
  endtask

  task automatic test_wrap();
    logic pu, po;
    logic [PS-1:0] pd, ed;
    logic [1:0] pr;
    logic [PS-1:0] pkts [10];
    int sent, got;
    for (int i = 0; i < 10; i++) pkts[i] = rand_pkt();
    sent = 0;
    got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      cycle(sent < 10, pkts[sent % 10], 1'b1, pu, po, pd, pr, ed);
      if (pu) sent++;
      if (po) begin
        checks++; if (pd !== pkts[got]) begin failures++; $display("FAIL wrap_order idx=%0d got=%h want=%h", got, pd, pkts[got]); end
        got++;
      end
      checks++; if (bus.occupancy > CW'(D) || bus.occupancy !== CW'(exp_q.size())) begin failures++; $display("FAIL wrap_occ got=%0d want=%0d", bus.occupancy, exp_q.size()); end
    end
    checks++; if (got != 10) begin failures++; $display("FAIL wrap_count got=%0d want=10", got); end
  endtask

  task automatic test_random();
    logic pu, po;
    logic [PS-1:0] pd, ed;
    logic [1:0] pr;
    for (int c = 0; c < 300; c++) begin
      if (bus.sa_req === 1'b1) begin
        checks++; if (bus.sa_dir === 2'b11) begin failures++; $display("FAIL rand_illegal_dir got=11 want=legal"); end
      end
      cycle(1'($urandom_range(0, 1)), rand_pkt(), $urandom_range(0, 3) != 0, pu, po, pd, pr, ed);
      if (po) begin
        checks++; if (pd !== ed || pr !== dir_of(ed)) begin failures++; $display("FAIL rand_pop got=%h/%b want=%h/%b", pd, pr, ed, dir_of(ed)); end
      end
      checks++; if (bus.occupancy !== CW'(exp_q.size())) begin failures++; $display("FAIL rand_occ got=%0d want=%0d", bus.occupancy, exp_q.size()); end
    end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      cycle(1'b0, '0, 1'b1, pu, po, pd, pr, ed);
      if (po) begin
        checks++; if (pd !== ed) begin failures++; $display("FAIL rand_drain got=%h want=%h", pd, ed); end
      end
    end
    checks++; if (exp_q.size() != 0 || bus.occupancy !== '0) begin failures++; $display("FAIL rand_drain_timeout got=%0d want=0", bus.occupancy); end
  endtask

  task automatic test_reset_mid();
    logic pu, po;
    logic [PS-1:0] pd, ed;
    logic [1:0] pr;
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_pkt(), 1'b0, pu, po, pd, pr, ed);
    checks++; if (bus.sa_req !== 1'b1 || bus.occupancy !== CW'(3)) begin failures++; $display("FAIL rmid_setup got=%0b/%0d want=1/3", bus.sa_req, bus.occupancy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.sa_req !== 1'b0) begin failures++; $display("FAIL rmid_async_req got=%0b want=0", bus.sa_req); end
    checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL rmid_async_occ got=%0d want=0", bus.occupancy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b1, pu, po, pd, pr, ed);
      checks++; if (bus.sa_req !== 1'b0 || bus.route_update_en !== 1'b0 || bus.occupancy !== '0) begin
        failures++; $display("FAIL rmid_stale cycle=%0d got=%0b/%0b/%0d want=0/0/0", i, bus.sa_req, bus.route_update_en, bus.occupancy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_simul();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
